ex_stage_mdu: RTL and testbench

- Parametrised execute stage for the MIPS pipeline; successor to the combinational EX stage.
- Contains the ALU, branch-target adder and destination-register select.
- Adds an iterative multiply/divide unit with HI/LO registers, a valid/ready input handshake, a registered EX/MEM output and a flush.
- Sits between the ID/EX latch and the MEM stage; stalls the front end while mul/div is busy.

---
 rtl/ex_stage_mdu_if.sv | 49 ++++
 rtl/ex_stage_mdu.sv | 220 ++++++++++++++++++++++
 tb/tb_ex_stage_mdu.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_mdu_if.sv
// ID/EX -> EX/MEM bus of the execute stage.
// Handshake: an op transfers on a rising clk edge where in_valid && in_ready
// && !flush; the master holds the op fields stable while in_valid is high.
// out_valid marks the EX/MEM register contents valid for exactly one cycle
// per completed op; the stage never back-pressures on the output side.
interface ex_stage_mdu_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic              alu_src;
  logic              reg_dst;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] extend;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              out_valid;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic [DATA_W-1:0] branch_target;
  logic [DATA_W-1:0] store_data;
  logic [REG_AW-1:0] dst_reg;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // ID/EX side (drives ops, consumes results)
  modport master (
    output flush, in_valid, op, alu_src, reg_dst, ctrl_in, pc, rdata1, rdata2,
           extend, rt, rd,
    input  in_ready, out_valid, ctrl_out, result, zero, branch_target,
           store_data, dst_reg, hi, lo
  );

  // Execute stage side
  modport slave (
    input  flush, in_valid, op, alu_src, reg_dst, ctrl_in, pc, rdata1, rdata2,
           extend, rt, rd,
    output in_ready, out_valid, ctrl_out, result, zero, branch_target,
           store_data, dst_reg, hi, lo
  );
endinterface

// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: ALU, branch-target adder, destination select and an
// iterative (one bit per cycle) multiply/divide unit with HI/LO registers.
// Results land in a registered EX/MEM output one cycle after acceptance
// (single-cycle ops) or DATA_W+1 cycles after acceptance (mul/div).
module ex_stage_mdu #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  ex_stage_mdu_if.slave  bus,
  output logic           dbg_busy_o
);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [3:0] OP_MFLO = 4'd5,  OP_MULT = 4'd11, OP_MULTU = 4'd12,
                         OP_DIV  = 4'd13, OP_DIVU = 4'd14, OP_MFHI  = 4'd15;

  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;

  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic              is_div_q, is_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic              out_valid_q, out_valid_d, zero_q, zero_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] result_q, result_d, bt_q, bt_d, store_q, store_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [REG_AW-1:0] dst_q, dst_d;

  logic [DATA_W-1:0]   op_b, alu_res, a_mag, b_mag;
  logic [SH_W-1:0]     shamt;
  logic                accept, is_mdu, signed_op, a_neg, b_neg;
  logic [DATA_W:0]     mul_sum, div_sh;
  logic [DATA_W-1:0]   step_rem, step_quo, quo_s, rem_s;
  logic [2*DATA_W-1:0] prod, prod_s;

  assign bus.in_ready      = (state_q == IDLE) && !rst;
  assign accept            = bus.in_valid && bus.in_ready && !bus.flush;
  assign op_b              = bus.alu_src ? bus.extend : bus.rdata2;
  assign shamt             = bus.rdata1[SH_W-1:0];
  assign is_mdu            = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  assign signed_op         = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg             = signed_op && bus.rdata1[DATA_W-1];
  assign b_neg             = signed_op && op_b[DATA_W-1];
  assign a_mag             = a_neg ? -bus.rdata1 : bus.rdata1;
  assign b_mag             = b_neg ? -op_b : op_b;

  // One iteration of shift-add multiply and restoring divide on magnitudes
  assign mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
  assign div_sh  = {rem_q, quo_q[DATA_W-1]};

  assign bus.out_valid     = out_valid_q;
  assign bus.ctrl_out      = ctrl_q;
  assign bus.result        = result_q;
  assign bus.zero          = zero_q;
  assign bus.branch_target = bt_q;
  assign bus.store_data    = store_q;
  assign bus.dst_reg       = dst_q;
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;
  assign dbg_busy_o        = (state_q == BUSY);

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (bus.op)
      4'd0:     alu_res = bus.rdata1 + op_b;
      4'd1:     alu_res = bus.rdata1 - op_b;
      4'd2:     alu_res = bus.rdata1 & op_b;
      4'd3:     alu_res = bus.rdata1 | op_b;
      4'd4:     alu_res = bus.rdata1 ^ op_b;
      OP_MFLO:  alu_res = lo_q;
      4'd6:     alu_res = {{(DATA_W-1){1'b0}}, $signed(bus.rdata1) < $signed(op_b)};
      4'd7:     alu_res = {{(DATA_W-1){1'b0}}, bus.rdata1 < op_b};
      4'd8:     alu_res = op_b << shamt;
      4'd9:     alu_res = op_b >> shamt;
      4'd10:    alu_res = $unsigned($signed(op_b) >>> shamt);
      OP_MFHI:  alu_res = hi_q;
      default:  alu_res = '0;
    endcase
  end

  // MDU step result and end-of-op sign fix-up
  always_comb begin
    if (is_div_q) begin
      if (div_sh >= {1'b0, dvs_q}) begin
        step_rem = div_sh[DATA_W-1:0] - dvs_q;
        step_quo = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        step_rem = div_sh[DATA_W-1:0];
        step_quo = {quo_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      step_rem = mul_sum[DATA_W:1];
      step_quo = {mul_sum[0], quo_q[DATA_W-1:1]};
    end
    prod   = {step_rem, step_quo};
    prod_s = neg_q_q ? -prod : prod;
    quo_s  = neg_q_q ? -step_quo : step_quo;
    rem_s  = neg_r_q ? -step_rem : step_rem;
  end

  // FSM next state and EX/MEM / HI/LO next values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    is_div_d    = is_div_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    out_valid_d = 1'b0;
    ctrl_d      = ctrl_q;
    result_d    = result_q;
    zero_d      = zero_q;
    bt_d        = bt_q;
    store_d     = store_q;
    dst_d       = dst_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (bus.flush) begin
      // abort: HI/LO are only written on the final iteration, so they keep
      // their pre-op values
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ctrl_d  = bus.ctrl_in;
            bt_d    = bus.pc + (bus.extend << 2);
            store_d = bus.rdata2;
            dst_d   = bus.reg_dst ? bus.rd : bus.rt;
            if (is_mdu) begin
              state_d  = BUSY;
              cnt_d    = '0;
              rem_d    = '0;
              quo_d    = a_mag;
              dvs_d    = b_mag;
              dvd_d    = bus.rdata1;
              is_div_d = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
              neg_q_d  = a_neg ^ b_neg;
              neg_r_d  = a_neg;
            end else begin
              out_valid_d = 1'b1;
              result_d    = alu_res;
              zero_d      = (alu_res == '0);
            end
          end
        end
        BUSY: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SH_W'(DATA_W-1)) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            if (!is_div_q) begin
              {hi_d, lo_d} = prod_s;
            end else if (dvs_q == '0) begin
              hi_d = dvd_q;
              lo_d = '1;
            end else begin
              hi_d = rem_s;
              lo_d = quo_s;
            end
            result_d = lo_d;
            zero_d   = (lo_d == '0);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      is_div_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      bt_q        <= '0;
      store_q     <= '0;
      dst_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      is_div_q    <= is_div_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      bt_q        <= bt_d;
      store_q     <= store_d;
      dst_q       <= dst_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Bench for ex_stage_mdu: directed cases plus random ALU and mul/div ops,
// checked against an arithmetic reference model of the MIPS semantics.
module tb_ex_stage_mdu;
  localparam int W = 32;

  logic clk;
  logic rst;
  logic dbg_busy;
  int   checks;
  int   errors;
  logic [W-1:0] hi_m, lo_m;
  logic [W-1:0] exp_q[$];

  ex_stage_mdu_if #(.DATA_W(W), .REG_AW(5), .CTRL_W(5)) bus();

  ex_stage_mdu #(.DATA_W(W), .REG_AW(5), .CTRL_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_busy_o (dbg_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // reference model
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return lo_m;
      4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << a[4:0];
      4'd9:  return b >> a[4:0];
      4'd10: return sb >>> a[4:0];
      4'd15: return hi_m;
      default: return '0;
    endcase
  endfunction

  task automatic ref_mdu(input logic [3:0] op, input logic [W-1:0] a, b,
                         output logic [W-1:0] h, output logic [W-1:0] l);
    int sa, sb;
    longint sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    h = '0;
    l = '0;
    if (op == 4'd11) begin
      sp = longint'(sa) * longint'(sb);
      {h, l} = sp;
    end else if (op == 4'd12) begin
      up = {32'd0, a} * {32'd0, b};
      {h, l} = up;
    end else if (b == 0) begin
      h = a;
      l = '1;
    end else if (op == 4'd13 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      h = 0;
      l = 32'h8000_0000;
    end else if (op == 4'd13) begin
      l = sa / sb;
      h = sa % sb;
    end else begin
      l = a / b;
      h = a % b;
    end
  endtask

  // drivers
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, b, ext,
                       input logic src, rdst, input logic [4:0] rt_v, rd_v, ctrl_v,
                       input logic [W-1:0] pc_v);
    bus.op = op; bus.rdata1 = a; bus.rdata2 = b; bus.extend = ext;
    bus.alu_src = src; bus.reg_dst = rdst; bus.rt = rt_v; bus.rd = rd_v;
    bus.ctrl_in = ctrl_v; bus.pc = pc_v; bus.in_valid = 1'b1;
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [W-1:0] a, b, ext,
                            input logic src, rdst, input logic [4:0] rt_v, rd_v, ctrl_v,
                            input logic [W-1:0] pc_v);
    logic [W-1:0] r;
    @(negedge clk);
    chk({tag, ".in_ready"}, W'(bus.in_ready), 1);
    drive(op, a, b, ext, src, rdst, rt_v, rd_v, ctrl_v, pc_v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    r = ref_alu(op, a, src ? ext : b);
    chk({tag, ".out_valid"}, W'(bus.out_valid), 1);
    chk({tag, ".result"}, bus.result, r);
    chk({tag, ".zero"}, W'(bus.zero), W'(r == 0));
    chk({tag, ".dst"}, W'(bus.dst_reg), W'(rdst ? rd_v : rt_v));
    chk({tag, ".ctrl"}, W'(bus.ctrl_out), W'(ctrl_v));
    chk({tag, ".store"}, bus.store_data, b);
    chk({tag, ".bt"}, bus.branch_target, pc_v + (ext << 2));
  endtask

  task automatic run_mdu(input string tag, input logic [3:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] eh, el;
    int k;
    ref_mdu(op, a, b, eh, el);
    @(negedge clk);
    drive(op, a, b, $urandom, 1'b0, 1'b1, 5'd3, 5'd17, 5'd9, 32'h400);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".busy_ready"}, W'(bus.in_ready), 0);
    k = 1;
    while (!bus.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, W'(k), W'(W + 1));
    chk({tag, ".in_ready"}, W'(bus.in_ready), 1);
    chk({tag, ".hi"}, bus.hi, eh);
    chk({tag, ".lo"}, bus.lo, el);
    chk({tag, ".result"}, bus.result, el);
    chk({tag, ".dst"}, W'(bus.dst_reg), 17);
    hi_m = eh;
    lo_m = el;
  endtask

  initial begin
    logic [3:0] op;
    logic [W-1:0] a, b, ext, r;
    logic src;
    checks = 0;
    errors = 0;
    hi_m = '0;
    lo_m = '0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0; bus.alu_src = 1'b0;
    bus.reg_dst = 1'b0; bus.ctrl_in = '0; bus.pc = '0; bus.rdata1 = '0;
    bus.rdata2 = '0; bus.extend = '0; bus.rt = '0; bus.rd = '0;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", W'(bus.in_ready), 0);
    chk("rst.out_valid", W'(bus.out_valid), 0);
    chk("rst.result", bus.result, 0);
    chk("rst.hi", bus.hi, 0);
    chk("rst.lo", bus.lo, 0);
    rst = 1'b0;

    // directed single-cycle cases
    run_single("add", 4'd0, 5, 7, 0, 1'b0, 1'b1, 5'd2, 5'd9, 5'd21, 32'h40);
    run_single("sub0", 4'd1, 32'h1234, 32'h1234, 0, 1'b0, 1'b0, 5'd6, 5'd9, 5'd1, 32'h80);
    run_single("branch", 4'd0, 1, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd4, 5'd5, 5'd16, 32'h100);
    chk("branch.fc", bus.branch_target, 32'hFC);
    run_single("slt", 4'd6, 32'hFFFF_FFFF, 1, 0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 0);
    chk("slt.one", bus.result, 1);
    run_single("sltu", 4'd7, 32'hFFFF_FFFF, 1, 0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 0);
    chk("sltu.zero", bus.result, 0);
    run_single("sra_imm", 4'd10, 4, 0, 32'h8000_0010, 1'b1, 1'b0, 5'd7, 5'd8, 5'd2, 0);

    // directed mul/div
    run_mdu("mult", 4'd11, 32'hFFFF_FFFD, 7);
    chk("mult.hi_c", bus.hi, 32'hFFFF_FFFF);
    chk("mult.lo_c", bus.lo, 32'hFFFF_FFEB);
    run_single("mfhi", 4'd15, 0, 0, 0, 1'b0, 1'b1, 5'd0, 5'd4, 5'd0, 0);
    chk("mfhi.c", bus.result, 32'hFFFF_FFFF);
    run_mdu("div", 4'd13, 7, 32'hFFFF_FFFE);
    chk("div.lo_c", bus.lo, 32'hFFFF_FFFD);
    chk("div.hi_c", bus.hi, 1);
    run_mdu("divu0", 4'd14, 7, 0);
    chk("divu0.lo_c", bus.lo, 32'hFFFF_FFFF);
    chk("divu0.hi_c", bus.hi, 7);
    run_mdu("divmin", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divmin.lo_c", bus.lo, 32'h8000_0000);
    chk("divmin.hi_c", bus.hi, 0);

    // random mul/div
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(11, 14));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 300)) : $urandom);
      if ($urandom_range(0, 1) == 1) a = $signed(W'($urandom_range(0, 5000))) - 2500;
      run_mdu("rnd_mdu", op, a, b);
    end

    // back-to-back random single-cycle ops
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 11));
      if (op == 4'd11) op = 4'd15;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      ext = $urandom;
      src = 1'($urandom_range(0, 1));
      drive(op, a, b, ext, src, 1'b0, 5'd12, 5'd13, 5'($urandom_range(0, 31)), $urandom);
      exp_q.push_back(ref_alu(op, a, src ? ext : b));
      @(negedge clk);
      r = exp_q.pop_front();
      chk("b2b.valid", W'(bus.out_valid), 1);
      chk("b2b.result", bus.result, r);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("hold.valid", W'(bus.out_valid), 0);
    chk("hold.result", bus.result, r);

    // flush on 10th BUSY cycle of MULTU, with hi=lo=0xAA beforehand
    run_mdu("seed_aa", 4'd12, 32'h0001_A9AA, 32'h0066_3D81);
    chk("seed_aa.hi", bus.hi, 32'hAA);
    chk("seed_aa.lo", bus.lo, 32'hAA);
    @(negedge clk);
    drive(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush.valid", W'(bus.out_valid), 0);
    chk("flush.in_ready", W'(bus.in_ready), 1);
    chk("flush.busy", W'(dbg_busy), 0);
    chk("flush.hi", bus.hi, 32'hAA);
    chk("flush.lo", bus.lo, 32'hAA);
    repeat (W) @(negedge clk);
    chk("flush.late_valid", W'(bus.out_valid), 0);
    chk("flush.late_lo", bus.lo, 32'hAA);

    // reset in the middle of a DIV
    drive(4'd13, 100, 7, 0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h200);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.in_ready", W'(bus.in_ready), 0);
    chk("mrst.valid", W'(bus.out_valid), 0);
    chk("mrst.result", bus.result, 0);
    chk("mrst.bt", bus.branch_target, 0);
    chk("mrst.hi", bus.hi, 0);
    chk("mrst.lo", bus.lo, 0);
    chk("mrst.busy", W'(dbg_busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.ready_after", W'(bus.in_ready), 1);

    // op presented together with flush is dropped
    drive(4'd0, 1, 1, 0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flushacc.valid", W'(bus.out_valid), 0);
    chk("flushacc.result", bus.result, 0);
    repeat (2) @(negedge clk);
    chk("flushacc.idle", W'(bus.out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
